// File: rtl/cpm_ctrl.sv
// cpm_ctrl: bank of NUM_CNT event counters with a command port and a
// snapshot dump stream.
//
// Ports:
//   Clk, Rstn        - single rising-edge clock, asynchronous active-low reset
//   CmdVld/CmdRdy    - command handshake; CmdOp: 0 START, 1 STOP, 2 CLEAR, 3 SNAP
//   Event[NUM_CNT]   - per-counter increment request
//   Busy             - high whenever the controller is not IDLE
//   OutVld/OutRdy    - snapshot word handshake
//   OutIdx/OutData   - index and value of the current snapshot word
//   Ovf[NUM_CNT]     - sticky per-counter wrap flag
module cpm_ctrl #(
  parameter int NUM_CNT = 4,
  parameter int DW      = 8,
  localparam int IW     = (NUM_CNT > 1) ? $clog2(NUM_CNT) : 1
) (
  input  logic               Clk,
  input  logic               Rstn,
  input  logic               CmdVld,
  output logic               CmdRdy,
  input  logic [1:0]         CmdOp,
  input  logic [NUM_CNT-1:0] Event,
  output logic               Busy,
  output logic               OutVld,
  input  logic               OutRdy,
  output logic [IW-1:0]      OutIdx,
  output logic [DW-1:0]      OutData,
  output logic [NUM_CNT-1:0] Ovf
);

  typedef enum logic [1:0] {IDLE, RUN, DUMP} st_t;
  typedef enum logic [1:0] {OP_START, OP_STOP, OP_CLEAR, OP_SNAP} op_t;

  localparam logic [IW-1:0] LAST = IW'(NUM_CNT - 1);

  st_t               state, nxt_state, ret_state;
  logic              run;
  logic [DW-1:0]     cnt  [NUM_CNT];
  logic [DW-1:0]     snap [NUM_CNT];
  logic [IW-1:0]     out_idx;
  logic [NUM_CNT-1:0] ovf;

  logic cmd_acc, start_acc, stop_acc, clr_acc, snap_acc, word_acc, last_acc;

  // CmdRdy is low in DUMP, so no command can be accepted there.
  assign cmd_acc   = CmdVld && (state != DUMP);
  assign start_acc = cmd_acc && (CmdOp == OP_START) && (state == IDLE);
  assign stop_acc  = cmd_acc && (CmdOp == OP_STOP)  && (state == RUN);
  assign clr_acc   = cmd_acc && (CmdOp == OP_CLEAR);
  assign snap_acc  = cmd_acc && (CmdOp == OP_SNAP);
  assign word_acc  = (state == DUMP) && OutRdy;
  assign last_acc  = word_acc && (out_idx == LAST);

  // State register
  always_ff @(posedge Clk or negedge Rstn) begin
    if (!Rstn) state <= IDLE;
    else       state <= nxt_state;
  end

  // Next-state logic
  always_comb begin
    nxt_state = state;
    case (state)
      IDLE: begin
        if (start_acc)     nxt_state = RUN;
        else if (snap_acc) nxt_state = DUMP;
      end
      RUN: begin
        if (stop_acc)      nxt_state = IDLE;
        else if (snap_acc) nxt_state = DUMP;
      end
      DUMP: begin
        if (last_acc)      nxt_state = ret_state;
      end
      default:             nxt_state = IDLE;
    endcase
  end

  // Outputs
  always_comb begin
    CmdRdy  = (state != DUMP);
    Busy    = (state != IDLE);
    OutVld  = (state == DUMP);
    OutIdx  = out_idx;
    OutData = snap[out_idx];
    Ovf     = ovf;
  end

  // Datapath: run flag, counters, snapshot, dump index
  always_ff @(posedge Clk or negedge Rstn) begin
    if (!Rstn) begin
      run       <= 1'b0;
      cnt       <= '{default: '0};
      snap      <= '{default: '0};
      ovf       <= '0;
      out_idx   <= '0;
      ret_state <= IDLE;
    end else begin
      if (start_acc) run <= 1'b1;
      if (stop_acc)  run <= 1'b0;

      // Run flag is the registered value, so the START edge does not count
      // and the STOP edge does.
      if (clr_acc) begin
        cnt <= '{default: '0};
        ovf <= '0;
      end else if (run) begin
        for (int unsigned i = 0; i < NUM_CNT; i++) begin
          if (Event[i]) begin
            cnt[i] <= cnt[i] + DW'(1);
            if (&cnt[i]) ovf[i] <= 1'b1;
          end
        end
      end

      if (snap_acc) begin
        snap      <= cnt;
        ret_state <= state;
        out_idx   <= '0;
      end else if (word_acc) begin
        out_idx   <= last_acc ? '0 : out_idx + IW'(1);
      end
    end
  end

endmodule

// File: tb/tb_cpm_ctrl.sv
// Directed testbench for cpm_ctrl (NUM_CNT=4, DW=8). Inputs change and outputs
// are sampled on the falling clock edge.
module tb_cpm_ctrl;

  localparam logic [1:0] START = 2'd0, STOP = 2'd1, CLEAR = 2'd2, SNAP = 2'd3;

  logic       Clk = 1'b0;
  logic       Rstn = 1'b0;
  logic       CmdVld = 1'b0;
  logic       CmdRdy;
  logic [1:0] CmdOp = 2'd0;
  logic [3:0] Event = 4'd0;
  logic       Busy;
  logic       OutVld;
  logic       OutRdy = 1'b0;
  logic [1:0] OutIdx;
  logic [7:0] OutData;
  logic [3:0] Ovf;

  int tests = 0;
  int fails = 0;

  cpm_ctrl #(.NUM_CNT(4), .DW(8)) dut (
    .Clk(Clk), .Rstn(Rstn), .CmdVld(CmdVld), .CmdRdy(CmdRdy), .CmdOp(CmdOp),
    .Event(Event), .Busy(Busy), .OutVld(OutVld), .OutRdy(OutRdy),
    .OutIdx(OutIdx), .OutData(OutData), .Ovf(Ovf)
  );

  always #5 Clk = ~Clk;

  task automatic tick();
    @(negedge Clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One-cycle command with the given Event value in the accept cycle.
  task automatic cmd(input logic [1:0] op, input logic [3:0] ev);
    CmdVld = 1'b1; CmdOp = op; Event = ev;
    tick();
    CmdVld = 1'b0; Event = 4'd0;
  endtask

  task automatic events(input logic [3:0] ev, input int n);
    Event = ev;
    repeat (n) tick();
    Event = 4'd0;
  endtask

  // SNAP, then read all four words; exp holds word k in bits [8k+7:8k].
  task automatic dump_chk(input string tag, input logic [31:0] exp, input bit tog,
                          input logic [3:0] evd, input logic bret);
    cmd(SNAP, 4'd0);
    Event = evd;
    for (int k = 0; k < 4; k++) begin
      chk({tag, ".vld"}, 32'(OutVld), 32'd1);
      chk({tag, ".idx"}, 32'(OutIdx), 32'(k));
      chk({tag, ".data"}, 32'(OutData), 32'(exp[8*k +: 8]));
      chk({tag, ".cmdrdy"}, 32'(CmdRdy), 32'd0);
      if (tog) begin
        OutRdy = 1'b0;
        tick();
        chk({tag, ".hold_idx"}, 32'(OutIdx), 32'(k));
        chk({tag, ".hold_data"}, 32'(OutData), 32'(exp[8*k +: 8]));
      end
      OutRdy = 1'b1;
      tick();
      OutRdy = 1'b0;
    end
    Event = 4'd0;
    chk({tag, ".end_vld"}, 32'(OutVld), 32'd0);
    chk({tag, ".ret_busy"}, 32'(Busy), 32'(bret));
    chk({tag, ".end_cmdrdy"}, 32'(CmdRdy), 32'd1);
  endtask

  initial begin
    repeat (2) tick();
    chk("rst.busy", 32'(Busy), 32'd0);
    chk("rst.cmdrdy", 32'(CmdRdy), 32'd1);
    chk("rst.vld", 32'(OutVld), 32'd0);
    chk("rst.idx", 32'(OutIdx), 32'd0);
    chk("rst.ovf", 32'(Ovf), 32'd0);
    Rstn = 1'b1;
    tick();

    // Basic counting with Event=0101 for 10 cycles
    cmd(START, 4'd0);
    chk("start.busy", 32'(Busy), 32'd1);
    cmd(START, 4'd0);                       // no-op in RUN
    chk("start_again.busy", 32'(Busy), 32'd1);
    events(4'b0101, 10);
    cmd(STOP, 4'd0);
    chk("stop.busy", 32'(Busy), 32'd0);
    cmd(STOP, 4'd0);                        // no-op in IDLE
    chk("stop_again.busy", 32'(Busy), 32'd0);
    dump_chk("cnt10", 32'h000A_000A, 1'b0, 4'd0, 1'b0);

    // START-cycle event not counted, STOP-cycle event counted
    cmd(CLEAR, 4'd0);
    cmd(START, 4'b0001);
    cmd(STOP, 4'b0001);
    dump_chk("edge", 32'h0000_0001, 1'b0, 4'd0, 1'b0);

    // Wrap after 256 increments, then one more
    cmd(CLEAR, 4'd0);
    cmd(START, 4'd0);
    events(4'b0001, 255);
    chk("wrap.pre_ovf", 32'(Ovf), 32'd0);
    events(4'b0001, 1);
    chk("wrap.ovf", 32'(Ovf), 32'b0001);
    events(4'b0001, 1);
    cmd(STOP, 4'd0);
    dump_chk("wrap", 32'h0000_0001, 1'b0, 4'd0, 1'b0);
    chk("wrap.ovf_sticky", 32'(Ovf), 32'b0001);

    // CLEAR beats same-cycle events, Ovf cleared, state stays RUN
    cmd(START, 4'd0);
    events(4'b1111, 3);
    cmd(CLEAR, 4'b1111);
    chk("clr.ovf", 32'(Ovf), 32'd0);
    chk("clr.busy", 32'(Busy), 32'd1);
    dump_chk("clr", 32'h0000_0000, 1'b0, 4'd0, 1'b1);

    // Counters 5/6/7/8, dump with OutRdy toggling while counter0 keeps counting
    events(4'b1111, 5);
    events(4'b1110, 1);
    events(4'b1100, 1);
    events(4'b1000, 1);
    dump_chk("tog", 32'h0807_0605, 1'b1, 4'b0001, 1'b1);
    dump_chk("cont", 32'h0807_060D, 1'b0, 4'd0, 1'b1);

    // Reset in the middle of a dump
    cmd(SNAP, 4'd0);
    OutRdy = 1'b1;
    tick();
    tick();
    OutRdy = 1'b0;
    chk("mid.idx", 32'(OutIdx), 32'd2);
    chk("mid.data", 32'(OutData), 32'd7);
    #1 Rstn = 1'b0;
    #1;
    chk("mid_rst.vld", 32'(OutVld), 32'd0);
    chk("mid_rst.busy", 32'(Busy), 32'd0);
    chk("mid_rst.cmdrdy", 32'(CmdRdy), 32'd1);
    chk("mid_rst.idx", 32'(OutIdx), 32'd0);
    tick();
    Rstn = 1'b1;
    tick();
    dump_chk("post_rst", 32'h0000_0000, 1'b0, 4'd0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
